// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline-control types and constants
package mips_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use stall, branch flush and memory-freeze control
module hazard_detection_unit
    import mips_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  id_ex_memread,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mem_memaccess,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_write,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hazard_state_t     state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze, branch, load_use, running;
    logic              stall_inc, flush_inc;

    assign freeze   = ex_mem_memaccess & ~mem_ready;
    assign branch   = ex_branch_taken;
    assign load_use = id_ex_memread &
                      ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
    assign running  = (state != ST_FAULT);

    // A load-use shadowed by a taken branch is wrong-path and does not count as a stall.
    assign stall_inc = running & (freeze | (~branch & load_use));
    assign flush_inc = running & ~freeze & branch;

    always_comb begin
        next_state   = state;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b0;
        if (rst_n) begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (freeze) begin
                        if (state == ST_RUN) begin
                            next_state = ST_MEM_WAIT;
                        end else if (wait_cnt == WAIT_LAST) begin
                            next_state = ST_FAULT;
                        end
                    end else begin
                        next_state   = ST_RUN;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        if (branch) begin
                            pc_write     = 1'b1;
                            if_id_write  = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (load_use) begin
                            id_ex_bubble = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end
                    end
                end
                ST_FAULT: next_state = ST_FAULT;
                default:  next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (running) begin
                wait_cnt <= freeze ? wait_cnt + 1'b1 : '0;
            end
            if (next_state == ST_FAULT) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
